ibex_prefetch_buffer_nreq: RTL and testbench

Parametrised word-granular instruction prefetch buffer sitting between the IF stage and the instruction memory bus. Issues up to NUM_REQS outstanding bus requests, tracks in-flight responses with counters rather than fixed shift registers, and discards stale responses after a branch. Buffers fetched words in a FIFO of configurable depth. Successor to the fixed two-request prefetch buffer; compressed-instruction realignment stays in the IF stage.

---
 rtl/ibex_prefetch_pkg.sv | 19 +
 rtl/ibex_fetch_fifo_nd.sv | 59 +++++
 rtl/ibex_prefetch_buffer_nreq.sv | 146 ++++++++++++++
 tb/tb_ibex_prefetch_buffer_nreq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ibex_prefetch_pkg.sv
// Shared types and constants for the N-request instruction prefetch buffer.
package ibex_prefetch_pkg;

  localparam int unsigned MAX_REQS = 8;
  localparam int unsigned CNT_W    = $clog2(MAX_REQS + 1);

  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0080;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ibex_fetch_fifo_nd.sv
// Fetched-word FIFO of arbitrary depth with synchronous clear.
// Latency: push visible at head the following cycle (no bypass).
// Backpressure: push accepted when not full, or when full and popping the same cycle.
module ibex_fetch_fifo_nd
  import ibex_prefetch_pkg::*;
#(
  parameter int unsigned  DEPTH = 3,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  fetch_entry_t  push_dat_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (do_push & ~clear_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ibex_prefetch_buffer_nreq.sv
// Word prefetch buffer with up to NUM_REQS outstanding bus requests; IBEX_PREFETCH_PMP_EN adds PMP fault responses.
// Latency: rvalid in cycle N shows on valid_o in N+1; branch drives instr_req_o combinationally.
// Backpressure: stops issuing when FIFO plus live in-flight words reaches FIFO_DEPTH.
module ibex_prefetch_buffer_nreq
  import ibex_prefetch_pkg::*;
#(
  parameter int unsigned NUM_REQS   = 2,
  parameter int unsigned FIFO_DEPTH = 3,
  parameter logic [31:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_rvalid_i,
`ifdef IBEX_PREFETCH_PMP_EN
  input  logic        instr_pmp_err_i,
`endif
  output logic        busy_o
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]      fetch_addr_q, fetch_addr_d, resp_addr_q, resp_addr_d, held_addr_q;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d, discard_cnt_q, discard_cnt_d;
  logic             held_q, held_d, held_discard_q, held_discard_d;
  logic [FCW-1:0]   fifo_cnt;
  logic [31:0]      branch_tgt, occupancy, rsp_rdata;
  logic             can_issue, new_req, pmp_issue, bus_gnt, held_gnt, new_gnt, accept;
  logic             rsp_vld, rsp_err, rsp_ok, push, pop, head_vld;
  fetch_entry_t     push_dat, head;

  assign branch_tgt = word_align(branch_addr_i);
  // After a branch every in-flight word is stale, so nothing occupies space for the new stream.
  assign occupancy  = branch_i ? 32'd0
                               : 32'(fifo_cnt) + 32'(out_cnt_q) - 32'(discard_cnt_q);
  assign can_issue  = req_i & (out_cnt_q < CNT_W'(NUM_REQS)) & (occupancy < FIFO_DEPTH);

`ifdef IBEX_PREFETCH_PMP_EN
  logic pmp_rsp_q;
  // Faulting fetches wait for older bus responses so the synthetic error stays in order.
  assign pmp_issue = instr_pmp_err_i & ~held_q & can_issue & (out_cnt_q == '0);
  assign new_req   = ~held_q & can_issue & ~instr_pmp_err_i;
  assign rsp_vld   = instr_rvalid_i | pmp_rsp_q;
  assign rsp_rdata = pmp_rsp_q ? 32'd0 : instr_rdata_i;
  assign rsp_err   = pmp_rsp_q | instr_err_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pmp_rsp_q <= 1'b0;
    else       pmp_rsp_q <= pmp_issue;
  end
`else
  assign pmp_issue = 1'b0;
  assign new_req   = ~held_q & can_issue;
  assign rsp_vld   = instr_rvalid_i;
  assign rsp_rdata = instr_rdata_i;
  assign rsp_err   = instr_err_i;
`endif

  assign instr_req_o  = held_q | new_req;
  assign instr_addr_o = held_q ? held_addr_q : (branch_i ? branch_tgt : fetch_addr_q);
  assign bus_gnt      = instr_req_o & instr_gnt_i;
  assign held_gnt     = held_q & bus_gnt;
  assign new_gnt      = (new_req & instr_gnt_i) | pmp_issue;
  assign accept       = new_req | pmp_issue;

  assign rsp_ok = rsp_vld & (out_cnt_q != '0);
  assign push   = rsp_ok & ~branch_i & (discard_cnt_q == '0);
  assign pop    = ready_i & head_vld;

  always_comb begin
    out_cnt_d      = out_cnt_q + CNT_W'(held_gnt | new_gnt) - CNT_W'(rsp_ok);
    held_d         = held_q ? ~bus_gnt : (new_req & ~instr_gnt_i);
    held_discard_d = held_q & ~bus_gnt & (held_discard_q | branch_i);

    // The pointer advances when an address first goes out; a held request already moved it.
    fetch_addr_d = fetch_addr_q;
    if (accept)        fetch_addr_d = instr_addr_o + 32'd4;
    else if (branch_i) fetch_addr_d = branch_tgt;

    resp_addr_d   = resp_addr_q;
    discard_cnt_d = discard_cnt_q;
    if (branch_i) begin
      resp_addr_d   = branch_tgt;
      discard_cnt_d = out_cnt_d - CNT_W'(new_gnt);
    end else begin
      if (push) resp_addr_d = resp_addr_q + 32'd4;
      if (rsp_ok && discard_cnt_q != '0) discard_cnt_d = discard_cnt_d - CNT_W'(1);
      if (held_gnt & held_discard_q)     discard_cnt_d = discard_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_addr_q   <= word_align(BOOT_ADDR);
      resp_addr_q    <= word_align(BOOT_ADDR);
      held_addr_q    <= word_align(BOOT_ADDR);
      out_cnt_q      <= '0;
      discard_cnt_q  <= '0;
      held_q         <= 1'b0;
      held_discard_q <= 1'b0;
    end else begin
      fetch_addr_q   <= fetch_addr_d;
      resp_addr_q    <= resp_addr_d;
      held_addr_q    <= instr_addr_o;
      out_cnt_q      <= out_cnt_d;
      discard_cnt_q  <= discard_cnt_d;
      held_q         <= held_d;
      held_discard_q <= held_discard_d;
    end
  end

  assign push_dat = '{rdata: rsp_rdata, addr: resp_addr_q, err: rsp_err};

  ibex_fetch_fifo_nd #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (branch_i),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .valid_o    (head_vld),
    .count_o    (fifo_cnt)
  );

  assign valid_o = head_vld;
  assign rdata_o = head_vld ? head.rdata : 32'd0;
  assign addr_o  = head_vld ? head.addr  : 32'd0;
  assign err_o   = head_vld & head.err;
  assign busy_o  = instr_req_o | (out_cnt_q != '0);

endmodule

// File: tb/tb_ibex_prefetch_buffer_nreq.sv
// Directed vector bench for ibex_prefetch_buffer_nreq at NUM_REQS=2, FIFO_DEPTH=3.
module tb_ibex_prefetch_buffer_nreq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req, br, rdy, gnt, rv, rerr;
  logic [31:0] baddr, rd;
  logic        valid_o, err_o, instr_req_o, busy_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;

  always #5 clk = ~clk;

  ibex_prefetch_buffer_nreq dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .branch_i       (br),
    .branch_addr_i  (baddr),
    .ready_i        (rdy),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .err_o          (err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (gnt),
    .instr_addr_o   (instr_addr_o),
    .instr_rdata_i  (rd),
    .instr_err_i    (rerr),
    .instr_rvalid_i (rv),
    .busy_o         (busy_o)
  );

  typedef struct {
    logic        req; logic br; logic [31:0] ba; logic rdy; logic gnt; logic rv; logic [31:0] rd; logic re;
    logic        ireq; logic [31:0] ia; logic vld; logic [31:0] dat; logic [31:0] adr; logic er; logic bsy;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    req = 1'b0; br = 1'b0; baddr = 32'h0; rdy = 1'b0;
    gnt = 1'b0; rv = 1'b0; rd = 32'h0; rerr = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    req = v.req; br = v.br; baddr = v.ba; rdy = v.rdy;
    gnt = v.gnt; rv = v.rv; rd = v.rd; rerr = v.re;
  endtask

  initial begin
    idle();
    //              req br ba         rdy gnt rv rd            re  ireq ia         vld dat           adr        er bsy
    // branch to 0x100, grant immediately, responses one cycle later
    vecs.push_back('{H, H, 32'h100, L, H, L, Z,            L,  H, 32'h100, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       H, H, H, 32'h1111_0100, L, H, 32'h104, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       H, H, H, 32'h1111_0104, L, H, 32'h108, H, 32'h1111_0100, 32'h100,  L, H});
    vecs.push_back('{L, L, Z,       H, L, H, 32'h1111_0108, L, L, 32'h10C, H, 32'h1111_0104, 32'h104,  L, H});
    vecs.push_back('{L, L, Z,       H, L, L, Z,            L,  L, 32'h10C, H, 32'h1111_0108, 32'h108,  L, L});
    vecs.push_back('{L, L, Z,       H, L, L, Z,            L,  L, 32'h10C, L, Z,            Z,         L, L});
    // withhold rvalid: only two grants, gnt without req ignored
    vecs.push_back('{H, L, Z,       H, H, L, Z,            L,  H, 32'h10C, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       H, H, L, Z,            L,  H, 32'h110, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       H, H, L, Z,            L,  L, 32'h114, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       H, H, L, Z,            L,  L, 32'h114, L, Z,            Z,         L, H});
    // branch to 0x200 with two outstanding: both old responses dropped
    vecs.push_back('{H, H, 32'h200, H, L, L, Z,            L,  L, 32'h200, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       H, L, H, 32'hDEAD_010C, L, L, 32'h200, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       H, H, H, 32'hDEAD_0110, L, H, 32'h200, L, Z,            Z,         L, H});
    vecs.push_back('{L, L, Z,       H, L, H, 32'hC0DE_0200, L, L, 32'h204, L, Z,            Z,         L, H});
    vecs.push_back('{L, L, Z,       L, L, L, Z,            L,  L, 32'h204, H, 32'hC0DE_0200, 32'h200,  L, L});
    vecs.push_back('{L, L, Z,       H, L, L, Z,            L,  L, 32'h204, H, 32'hC0DE_0200, 32'h200,  L, L});
    vecs.push_back('{L, L, Z,       H, L, L, Z,            L,  L, 32'h204, L, Z,            Z,         L, L});
    // grant withheld, branch to 0x300 during hold; held word discarded
    vecs.push_back('{H, L, Z,       H, L, L, Z,            L,  H, 32'h204, L, Z,            Z,         L, H});
    vecs.push_back('{L, L, Z,       H, L, L, Z,            L,  H, 32'h204, L, Z,            Z,         L, H});
    vecs.push_back('{H, H, 32'h300, H, L, L, Z,            L,  H, 32'h204, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       H, H, L, Z,            L,  H, 32'h204, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       H, H, L, Z,            L,  H, 32'h300, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       H, L, H, 32'hBAD0_0204, L, L, 32'h304, L, Z,            Z,         L, H});
    vecs.push_back('{L, L, Z,       H, L, H, 32'hC0DE_0300, L, L, 32'h304, L, Z,            Z,         L, H});
    vecs.push_back('{L, L, Z,       H, L, L, Z,            L,  L, 32'h304, H, 32'hC0DE_0300, 32'h300,  L, L});
    // ready low: issue stops once fifo + outstanding reaches 3
    vecs.push_back('{H, L, Z,       L, H, L, Z,            L,  H, 32'h304, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       L, H, H, 32'hE000_0304, L, H, 32'h308, L, Z,            Z,         L, H});
    vecs.push_back('{H, L, Z,       L, H, H, 32'hE000_0308, L, H, 32'h30C, H, 32'hE000_0304, 32'h304,  L, H});
    vecs.push_back('{H, L, Z,       L, H, L, Z,            L,  L, 32'h310, H, 32'hE000_0304, 32'h304,  L, H});
    vecs.push_back('{H, L, Z,       L, L, H, 32'hE000_030C, L, L, 32'h310, H, 32'hE000_0304, 32'h304,  L, H});
    vecs.push_back('{H, L, Z,       L, L, L, Z,            L,  L, 32'h310, H, 32'hE000_0304, 32'h304,  L, L});
    // drain, then an errored word at 0x310 with fetching continuing
    vecs.push_back('{H, L, Z,       H, H, L, Z,            L,  L, 32'h310, H, 32'hE000_0304, 32'h304,  L, L});
    vecs.push_back('{H, L, Z,       H, H, L, Z,            L,  H, 32'h310, H, 32'hE000_0308, 32'h308,  L, H});
    vecs.push_back('{H, L, Z,       H, H, H, 32'hEEEE_0310, H, H, 32'h314, H, 32'hE000_030C, 32'h30C,  L, H});
    vecs.push_back('{L, L, Z,       H, L, H, 32'hE000_0314, L, L, 32'h318, H, 32'hEEEE_0310, 32'h310,  H, H});
    vecs.push_back('{L, L, Z,       H, L, L, Z,            L,  L, 32'h318, H, 32'hE000_0314, 32'h314,  L, L});
    // rvalid with nothing outstanding is ignored
    vecs.push_back('{L, L, Z,       H, L, H, 32'h5A5A_5A5A, L, L, 32'h318, L, Z,            Z,         L, L});
    vecs.push_back('{L, L, Z,       H, L, L, Z,            L,  L, 32'h318, L, Z,            Z,         L, L});

    repeat (2) @(negedge clk);
    #1;
    chk1 ("rst.instr_req", instr_req_o, 1'b0);
    chk1 ("rst.valid", valid_o, 1'b0);
    chk1 ("rst.busy", busy_o, 1'b0);
    chk1 ("rst.err", err_o, 1'b0);
    chk32("rst.rdata", rdata_o, 32'h0);
    chk32("rst.addr", addr_o, 32'h0);
    chk32("rst.instr_addr", instr_addr_o, 32'h80);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk1 ($sformatf("v%0d.instr_req", i), instr_req_o, vecs[i].ireq);
      chk32($sformatf("v%0d.instr_addr", i), instr_addr_o, vecs[i].ia);
      chk1 ($sformatf("v%0d.valid", i), valid_o, vecs[i].vld);
      chk1 ($sformatf("v%0d.busy", i), busy_o, vecs[i].bsy);
      if (vecs[i].vld) begin
        chk32($sformatf("v%0d.rdata", i), rdata_o, vecs[i].dat);
        chk32($sformatf("v%0d.addr", i), addr_o, vecs[i].adr);
        chk1 ($sformatf("v%0d.err", i), err_o, vecs[i].er);
      end
    end

    // reset in the middle of a granted request plus a held one
    @(negedge clk); idle(); req = 1'b1; gnt = 1'b1; #1;
    chk1 ("mid.req0", instr_req_o, 1'b1);
    chk32("mid.addr0", instr_addr_o, 32'h318);
    @(negedge clk); gnt = 1'b0; #1;
    chk1 ("mid.req1", instr_req_o, 1'b1);
    chk32("mid.addr1", instr_addr_o, 32'h31C);
    @(posedge clk); #2;
    req = 1'b0; rst = 1'b1; #1;
    chk1 ("arst.instr_req", instr_req_o, 1'b0);
    chk1 ("arst.busy", busy_o, 1'b0);
    chk32("arst.instr_addr", instr_addr_o, 32'h80);
    @(negedge clk); rst = 1'b0; rv = 1'b1; rd = 32'hDEAD_BEEF; #1;
    chk1 ("late_rv.busy", busy_o, 1'b0);
    @(negedge clk); idle(); #1;
    chk1 ("late_rv.valid", valid_o, 1'b0);

    // first fetch after reset comes from the boot address
    @(negedge clk); req = 1'b1; gnt = 1'b1; #1;
    chk1 ("boot.req", instr_req_o, 1'b1);
    chk32("boot.addr", instr_addr_o, 32'h80);
    @(negedge clk); idle(); rv = 1'b1; rd = 32'h0B00_0080; #1;
    chk1 ("boot.busy", busy_o, 1'b1);
    @(negedge clk); idle(); rdy = 1'b1; #1;
    chk1 ("boot.valid", valid_o, 1'b1);
    chk32("boot.rdata", rdata_o, 32'h0B00_0080);
    chk32("boot.head_addr", addr_o, 32'h80);
    @(negedge clk); idle(); #1;
    chk1 ("boot.drained", valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
